// File: rtl/bus8_master_pkg.sv
// Shared types and constants for the Bus8 UART command master.
// Holds the FSM state enum, command opcodes and the write-ack byte.
package bus8_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_TX_SEND
    } state_t;

    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/bus8_timeout_ctr.sv
// Wait-state timeout counter for the Bus8 UART master.
// Ports: clk_i, rst_i (sync, active high), clear_i, enable_i, expired_o.
// expired_o is high on the CLKS_TIMEOUT-th enabled cycle after a clear.
module bus8_timeout_ctr
    import bus8_master_pkg::*;
#(
    parameter int CLKS_TIMEOUT = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(CLKS_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(CLKS_TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturate at LAST so a stalled owner cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/bus8_uart_master.sv
// UART-command to Bus8 master: parses write/read commands from RX bytes,
// issues single-cycle Bus8 strobes and returns read data / error byte on TX.
// Ports: i_Bus_Clk, i_Bus_Rst (sync high), i_Rx_DV/i_Rx_Byte, i_Tx_Active,
// o_Tx_DV/o_Tx_Byte, o_Bus_CS/o_Bus_Wr_Rd_n/o_Bus_Addr8/o_Bus_Wr_Data,
// i_Bus_Rd_Data/i_Bus_Rd_DV, o_Err.
// Define BUS8_MASTER_WR_ACK_EN to answer each write with ACK_BYTE.
module bus8_uart_master
    import bus8_master_pkg::*;
#(
    parameter int          CLKS_TIMEOUT = 1000,
    parameter logic [7:0]  ERR_BYTE     = 8'hEE
) (
    input  logic       i_Bus_Clk,
    input  logic       i_Bus_Rst,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Tx_Active,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    output logic       o_Bus_CS,
    output logic       o_Bus_Wr_Rd_n,
    output logic [2:0] o_Bus_Addr8,
    output logic [7:0] o_Bus_Wr_Data,
    input  logic [7:0] i_Bus_Rd_Data,
    input  logic       i_Bus_Rd_DV,
    output logic       o_Err
);

    state_t     state_q;
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;
    logic       cs_q;
    logic       wr_rd_n_q;
    logic [2:0] addr_q;
    logic [7:0] wr_data_q;
    logic       err_q;

    logic waiting;
    logic expired;
    logic drop_state;

    assign waiting    = (state_q == ST_WR_DATA) || (state_q == ST_RD_WAIT);
    assign drop_state = (state_q == ST_BUS_WR) || (state_q == ST_BUS_RD) ||
                        (state_q == ST_RD_WAIT) || (state_q == ST_TX_SEND);

    bus8_timeout_ctr #(
        .CLKS_TIMEOUT (CLKS_TIMEOUT)
    ) u_tmo (
        .clk_i     (i_Bus_Clk),
        .rst_i     (i_Bus_Rst),
        .clear_i   (!waiting),
        .enable_i  (waiting),
        .expired_o (expired)
    );

    // A response byte is launched on the same edge it is produced when the
    // transmitter is idle, so a read answers at T+3; otherwise TX_SEND holds.
    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            state_q   <= ST_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            cs_q      <= 1'b0;
            wr_rd_n_q <= 1'b0;
            addr_q    <= 3'd0;
            wr_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            cs_q    <= 1'b0;
            tx_dv_q <= 1'b0;
            err_q   <= i_Rx_DV && drop_state;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte[7:6] == OP_WR) begin
                            addr_q  <= i_Rx_Byte[2:0];
                            state_q <= ST_WR_DATA;
                        end else if (i_Rx_Byte[7:6] == OP_RD) begin
                            addr_q    <= i_Rx_Byte[2:0];
                            cs_q      <= 1'b1;
                            wr_rd_n_q <= 1'b0;
                            state_q   <= ST_BUS_RD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (i_Rx_DV) begin
                        wr_data_q <= i_Rx_Byte;
                        cs_q      <= 1'b1;
                        wr_rd_n_q <= 1'b1;
                        state_q   <= ST_BUS_WR;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUS_WR: begin
`ifdef BUS8_MASTER_WR_ACK_EN
                    tx_byte_q <= ACK_BYTE;
                    if (!i_Tx_Active) begin
                        tx_dv_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_TX_SEND;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                ST_BUS_RD: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (i_Bus_Rd_DV || expired) begin
                        tx_byte_q <= i_Bus_Rd_DV ? i_Bus_Rd_Data : ERR_BYTE;
                        if (!i_Bus_Rd_DV) begin
                            err_q <= 1'b1;
                        end
                        if (!i_Tx_Active) begin
                            tx_dv_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_TX_SEND;
                        end
                    end
                end
                ST_TX_SEND: begin
                    if (!i_Tx_Active) begin
                        tx_dv_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_DV       = tx_dv_q;
    assign o_Tx_Byte     = tx_byte_q;
    assign o_Bus_CS      = cs_q;
    assign o_Bus_Wr_Rd_n = wr_rd_n_q;
    assign o_Bus_Addr8   = addr_q;
    assign o_Bus_Wr_Data = wr_data_q;
    assign o_Err         = err_q;

endmodule

// File: doc/bus8_uart_master.md
# bus8_uart_master

Command-parsing bus master sitting directly upstream of the 8-register Bus8 block: consumes bytes from a UART receiver, turns them into single-cycle Bus8 write/read transactions, and returns read data (or an error byte) to a UART transmitter. It is the host-side entry point for poking FPGA registers over a serial link.

## Interface
- CLKS_TIMEOUT, 1000: cycles allowed for a pending write-data byte or a read response before abort.
- ERR_BYTE, 8'hEE: byte transmitted when a read times out.
- i_Bus_Clk  in  1  single clock for all logic.
- i_Bus_Rst  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle strobe, i_Rx_Byte valid.
- i_Rx_Byte  in  8  received byte.
- i_Tx_Active  in  1  UART TX busy; o_Tx_DV must not pulse while high.
- o_Tx_DV  out  1  one-cycle strobe, o_Tx_Byte valid.
- o_Tx_Byte  out  8  byte to transmit.
- o_Bus_CS  out  1  one-cycle transaction strobe.
- o_Bus_Wr_Rd_n  out  1  1 = write, 0 = read.
- o_Bus_Addr8  out  3  register address.
- o_Bus_Wr_Data  out  8  write data.
- i_Bus_Rd_Data  in  8  read data from register block.
- i_Bus_Rd_DV  in  1  read data valid strobe.
- o_Err  out  1  one-cycle pulse: illegal command, dropped byte, or timeout.

## Operation
- Command byte: [7:6] opcode (2'b01 write, 2'b10 read, others illegal), [5:3] ignored, [2:0] address. Write is followed by one data byte.
- States: IDLE, WR_DATA, BUS_WR, BUS_RD, RD_WAIT, TX_SEND.
- IDLE: Rx write cmd -> latch addr, WR_DATA. Rx read cmd -> latch addr, BUS_RD. Illegal opcode -> o_Err, stay IDLE.
- WR_DATA: Rx byte -> latch o_Bus_Wr_Data, BUS_WR. Timeout -> o_Err, IDLE.
- BUS_WR: o_Bus_CS=1, o_Bus_Wr_Rd_n=1 for this cycle only -> IDLE (or TX_SEND with ack, see Configuration).
- BUS_RD: o_Bus_CS=1, o_Bus_Wr_Rd_n=0 for this cycle only -> RD_WAIT.
- RD_WAIT: i_Bus_Rd_DV -> latch i_Bus_Rd_Data into o_Tx_Byte, TX_SEND. Timeout -> o_Tx_Byte=ERR_BYTE, o_Err, TX_SEND.
- TX_SEND: when i_Tx_Active=0, pulse o_Tx_DV one cycle -> IDLE; otherwise hold.
- Timeout counter: cleared on entry to WR_DATA/RD_WAIT, increments each cycle there; timeout when count = CLKS_TIMEOUT-1 and no event that cycle. Event on the same cycle wins. Width $clog2(CLKS_TIMEOUT+1).
- i_Rx_DV in BUS_WR, BUS_RD, RD_WAIT, TX_SEND: byte dropped, o_Err pulses, state unaffected.
- i_Bus_Rd_DV outside RD_WAIT ignored.
- Reset: state IDLE; all outputs 0 (o_Bus_Wr_Rd_n=0, o_Bus_Addr8=0, o_Tx_Byte=0); counter 0. Reset mid-transaction aborts with no CS or Tx pulse on following cycle.

## Timing
- Write: data byte on cycle D -> o_Bus_CS high on D+1 only; IDLE on D+2; next command accepted from D+2.
- Read: cmd on cycle T -> o_Bus_CS high on T+1; register block returns i_Bus_Rd_DV on T+2 -> o_Tx_DV on T+3 if i_Tx_Active=0.
- o_Tx_DV, o_Bus_CS, o_Err are always single-cycle registered pulses.

## Configuration
- BUS8_MASTER_WR_ACK_EN defined: BUS_WR goes to TX_SEND with o_Tx_Byte=ACK_BYTE (8'hA5); host gets one byte per write.
- Undefined: BUS_WR returns to IDLE; writes produce no Tx traffic.

## Structure
- Package bus8_master_pkg: state enum, opcode constants OP_WR=2'b01, OP_RD=2'b10, ACK_BYTE.
- One sub-module: bus8_timeout_ctr (clear, enable, parameter CLKS_TIMEOUT, expired output).

## Test plan
- Rx 8'h43 then 8'h5A -> one CS cycle, Wr_Rd_n=1, Addr8=3, Wr_Data=8'h5A; no o_Err.
- Rx 8'h85, model returns 8'h3C on Rd_DV next cycle -> o_Tx_DV with o_Tx_Byte=8'h3C at T+3.
- Read with no Rd_DV, CLKS_TIMEOUT=16 -> o_Err and o_Tx_Byte=8'hEE after 16 RD_WAIT cycles.
- Rx 8'hC0 -> o_Err pulse, no CS; Rx 8'h41 with no data byte -> o_Err after timeout, no CS.
- i_Tx_Active held high 50 cycles during read response -> o_Tx_DV first cycle after it drops; Rx byte meanwhile -> o_Err, dropped.
- Reset asserted in RD_WAIT then late Rd_DV -> no Tx pulse; with BUS8_MASTER_WR_ACK_EN, write yields o_Tx_Byte=8'hA5.
